// File: rtl/rfifo_drain_arb.sv
// rtl/rfifo_drain_arb.sv - round-robin burst arbiter draining NUM_CH FIFO read ports into one stream
module rfifo_drain_arb #(
  parameter int NUM_CH    = 4,
  parameter int DATA_SIZE = 8,
  parameter int BURST_LEN = 4,
  parameter int CH_W      = 2
) (
  input  logic                        rclk,
  input  logic                        rrst,
  input  logic                        en,
  input  logic [NUM_CH-1:0]           rempty,
  input  logic [NUM_CH*DATA_SIZE-1:0] rdata,
  output logic [NUM_CH-1:0]           rinc,
  output logic [DATA_SIZE-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CH_W-1:0]             out_ch,
  output logic                        busy
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  logic [0:0]       state;
  logic [CH_W-1:0]  grant;
  logic [CH_W-1:0]  last;
  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0]  pick;
  logic             any_req;
  logic             grant_empty;
  logic             pop;

  // Search starts just after the last served channel so it becomes lowest priority.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      int idx;
      idx = (int'(last) + k) % NUM_CH;
      if (!any_req && !rempty[CH_W'(idx)]) begin
        pick    = CH_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    out_data    = rdata[DATA_SIZE-1:0];
    grant_empty = rempty[0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == CH_W'(i)) begin
        out_data    = rdata[i*DATA_SIZE +: DATA_SIZE];
        grant_empty = rempty[i];
      end
    end
  end

  // Reset gates the strobe combinationally so a reset cycle never pops a word.
  assign out_valid = (state == GRANT) && en && !grant_empty && !rrst;
  assign pop       = out_valid && out_ready;
  assign out_ch    = grant;
  assign busy      = (state == GRANT);

  always_comb begin
    rinc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rinc[i] = pop && (grant == CH_W'(i));
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= IDLE;
      grant <= '0;
      last  <= CH_W'(NUM_CH - 1);
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (en && any_req) begin
        grant <= pick;
        cnt   <= '0;
        state <= GRANT;
      end
    end else begin
      if (!en || grant_empty || (pop && cnt == CNT_LAST)) begin
        state <= IDLE;
        last  <= grant;
      end else if (pop) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
